// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, R/W bit values and default target address.
// Pure declarations; no timing or flow control.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ACK_ADDR  = 3'd2,
      ST_RX        = 3'd3,
      ST_ACK_RX    = 3'd4,
      ST_TX        = 3'd5,
      ST_WAIT_MACK = 3'd6,
      ST_IGNORE    = 3'd7
   } i2c_state_e;

   localparam logic I2C_RW_WRITE = 1'b0;
   localparam logic I2C_RW_READ  = 1'b1;

   localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h55;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes scl/sda and derives edge and START/STOP strobes (2 sync flops + 1 history flop).
// Strobes are single-cycle and unconditional; there is no backpressure.
module i2c_bus_sync (
   input  logic clk,
   input  logic reset,
   input  logic scl,
   input  logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [1:0] scl_sync_q, scl_sync_d;
   logic [1:0] sda_sync_q, sda_sync_d;
   logic       scl_hist_q, scl_hist_d;
   logic       sda_hist_q, sda_hist_d;
   logic       scl_s;

   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl};
      sda_sync_d = {sda_sync_q[0], sda};
      scl_hist_d = scl_sync_q[1];
      sda_hist_d = sda_sync_q[1];
   end

   // Reset to the idle-bus level so leaving reset never fakes an edge on a quiet bus.
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_hist_q <= scl_hist_d;
         sda_hist_q <= sda_hist_d;
      end
   end

   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign scl_rise  = scl_s & ~scl_hist_q;
   assign scl_fall  = ~scl_s & scl_hist_q;
   assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
   assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with a small auto-incrementing register bank; bus events act 3 clk after the pin.
// No backpressure: the bus master paces every transfer, the host port is a plain combinational read.
module i2c_reg_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = I2C_DEFAULT_ADDR,
   parameter int         NUM_REGS    = 4,
   localparam int        PW          = $clog2(NUM_REGS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          scl,
   inout  wire           sda,
   input  logic [PW-1:0] host_addr,
   output logic [7:0]    host_data,
   output logic          wr_valid,
   output logic [PW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic          busy,
   output logic [2:0]    state
);

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   i2c_bus_sync u_bus_sync (
      .clk       (clk),
      .reset     (reset),
      .scl       (scl),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   i2c_state_e    state_q, state_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic          first_byte_q, first_byte_d;
   logic          rw_q, rw_d;
   logic          sda_oe_q, sda_oe_d;
   logic          busy_q, busy_d;
   logic          wr_valid_q, wr_valid_d;
   logic [PW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic [7:0]    regs_q [NUM_REGS];
   logic [7:0]    regs_d [NUM_REGS];

   logic          byte_done;
   logic [7:0]    byte_in;
   logic [PW-1:0] ptr_inc;
   logic          addr_match;
   logic [7:0]    rd_byte;

   assign byte_done  = scl_rise && (bit_cnt_q == 4'd7);
   assign byte_in    = {shift_q[6:0], sda_s};
   assign ptr_inc    = ptr_q + PW'(1);
   assign addr_match = (byte_in[7:1] == TARGET_ADDR);
   assign rd_byte    = regs_q[ptr_q];

   // Next-state logic; START/STOP win over any scl edge seen in the same cycle.
   always_comb begin
      state_d = state_q;
      if (start_det) begin
         state_d = ST_ADDR;
      end else if (stop_det) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_ADDR:      if (byte_done) state_d = addr_match ? ST_ACK_ADDR : ST_IGNORE;
            ST_ACK_ADDR:  if (scl_fall && sda_oe_q) state_d = (rw_q == I2C_RW_READ) ? ST_TX : ST_RX;
            ST_RX:        if (byte_done) state_d = ST_ACK_RX;
            ST_ACK_RX:    if (scl_fall && sda_oe_q) state_d = ST_RX;
            ST_TX:        if (scl_fall && (bit_cnt_q == 4'd8)) state_d = ST_WAIT_MACK;
            ST_WAIT_MACK: if (scl_rise) state_d = sda_s ? ST_IGNORE : ST_TX;
            default:      state_d = state_q;
         endcase
      end
   end

   // Datapath: shift register, pointer, bus drive and write strobe.
   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      ptr_d        = ptr_q;
      first_byte_d = first_byte_q;
      rw_d         = rw_q;
      sda_oe_d     = sda_oe_q;
      busy_d       = busy_q;
      wr_valid_d   = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      if (start_det) begin
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else if (stop_det) begin
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
               if (byte_done && addr_match) begin
                  busy_d = 1'b1;
                  rw_d   = byte_in[0];
               end
            end
            ST_ACK_ADDR, ST_ACK_RX: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = 4'd0;
                     // A read must put bit 7 on the bus on the same fall that ends the ACK.
                     if (state_q == ST_ACK_ADDR && rw_q == I2C_RW_READ) begin
                        sda_oe_d  = ~rd_byte[7];
                        shift_d   = rd_byte << 1;
                        bit_cnt_d = 4'd1;
                     end else if (state_q == ST_ACK_ADDR && rw_q == I2C_RW_WRITE) begin
                        first_byte_d = 1'b1;
                     end
                  end
               end
            end
            ST_RX: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
               if (byte_done) begin
                  if (first_byte_q) begin
                     ptr_d        = byte_in[PW-1:0];
                     first_byte_d = 1'b0;
                  end else begin
                     wr_valid_d = 1'b1;
                     wr_addr_d  = ptr_q;
                     wr_data_d  = byte_in;
                     ptr_d      = ptr_inc;
                  end
               end
            end
            ST_TX: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                  end else begin
                     sda_oe_d  = ~shift_q[7];
                     shift_d   = shift_q << 1;
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            ST_WAIT_MACK: begin
               if (scl_rise) begin
                  ptr_d = ptr_inc;
                  if (sda_s) begin
                     busy_d = 1'b0;
                  end else begin
                     shift_d   = regs_q[ptr_inc];
                     bit_cnt_d = 4'd0;
                  end
               end
            end
            default: sda_oe_d = 1'b0;
         endcase
      end
   end

   // The bank is written from the registered strobe, one cycle after wr_valid shows.
   always_comb begin
      regs_d = regs_q;
      if (wr_valid_q) regs_d[wr_addr_q] = wr_data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= 4'd0;
         shift_q      <= 8'h00;
         ptr_q        <= '0;
         first_byte_q <= 1'b0;
         rw_q         <= 1'b0;
         sda_oe_q     <= 1'b0;
         busy_q       <= 1'b0;
         wr_valid_q   <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= 8'h00;
         regs_q       <= '{default: 8'h00};
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         ptr_q        <= ptr_d;
         first_byte_q <= first_byte_d;
         rw_q         <= rw_d;
         sda_oe_q     <= sda_oe_d;
         busy_q       <= busy_d;
         wr_valid_q   <= wr_valid_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         regs_q       <= regs_d;
      end
   end

   assign sda       = sda_oe_q ? 1'b0 : 1'bz;
   assign host_data = regs_q[host_addr];
   assign wr_valid  = wr_valid_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;
   assign state     = state_q;

endmodule

// File: doc/i2c_reg_target.md
# i2c_reg_target

Register-bank I2C target (responder) answering the existing I2C master on the shared `scl`/`sda` bus. It oversamples the bus on the system clock, detects START/STOP, matches a 7-bit address, and ACKs. A write transaction loads a register pointer, then writes bytes into a small register bank with auto-increment. A read transaction returns bytes from the pointer with auto-increment. A host-side port exposes the bank to local logic.

## Interface
- `TARGET_ADDR`, default 7'h55: 7-bit bus address this target answers.
- `NUM_REGS`, default 4: register count; power of two, 2..256. `PW = log2(NUM_REGS)`.
- `clk` input, 1 bit: single system clock. All logic is on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `scl` input, 1 bit: bus clock. It is asynchronous to `clk`.
- `sda` inout, 1 bit: open-drain. The block drives only `1'b0` or `1'bz`.
- `host_addr` input, PW bits: host read index.
- `host_data` output, 8 bits: `regs[host_addr]`, combinational.
- `wr_valid` output, 1 bit: one-cycle pulse for each data byte written by the bus.
- `wr_addr` output, PW bits: register index of that write.
- `wr_data` output, 8 bits: byte written.
- `busy` output, 1 bit: high from address match until STOP, START or NACK release.
- `state` output, 3 bits: current FSM state, for debug.

## Operation
- **Input sampling**
  - `scl` and `sda` pass through a 2-flop synchronizer, then a 1-flop history register.
  - `scl_rise`/`scl_fall` come from the synchronized `scl`.
- **Bus conditions**
  - START is `sda` falling while `scl` is high.
  - STOP is `sda` rising while `scl` is high.
  - START from any state (repeated START included) goes to ADDR, clears the bit counter and releases `sda`.
  - STOP from any state goes to IDLE and releases `sda`.
- **States (encoding)**
  - IDLE = 0, ADDR = 1, ACK_ADDR = 2, RX = 3, ACK_RX = 4, TX = 5, WAIT_MACK = 6, IGNORE = 7.
- **ADDR**
  - Shift 8 bits MSB-first on `scl_rise`: 7 address bits, then R/W.
  - On address match, go to ACK_ADDR and set `busy`.
  - On mismatch, go to IGNORE and never drive `sda`.
- **ACK_ADDR**
  - Pull `sda` low at the `scl_fall` after bit 8.
  - Release at the next `scl_fall`.
  - Then go to RX if W (`first_byte` flag set), or to TX if R (shift register loaded with `regs[ptr]`).
- **RX**
  - Shift 8 bits, then ACK exactly as in ACK_ADDR.
  - If `first_byte`: `ptr <= byte[PW-1:0]` (upper bits discarded), and clear `first_byte`.
  - Otherwise: `regs[ptr] <= byte`, pulse `wr_valid` with `wr_addr=ptr` and `wr_data=byte`, then `ptr <= ptr+1` modulo NUM_REGS.
  - The write commits on the `scl_rise` of bit 8.
- **TX**
  - Drive bit 7 at the `scl_fall` that ends the ACK. Drive each following bit on `scl_fall`.
  - A bit value of 1 releases `sda`.
  - After bit 0's `scl_fall`, release `sda` and go to WAIT_MACK.
- **WAIT_MACK**
  - Sample on `scl_rise`.
  - If 0 (ACK): `ptr <= ptr+1` (wrap), load `regs[ptr+1]`, return to TX.
  - If 1 (NACK): `ptr <= ptr+1`, go to IGNORE, clear `busy`.
- **IGNORE**
  - Hold `sda` released. Only START or STOP exit this state.
- **Reset** (also mid-transfer)
  - State = IDLE, `sda` = z, `regs` = 0, `ptr` = 0, `first_byte` = 0.
  - `busy`, `wr_valid`, `wr_addr` and `wr_data` = 0.
  - Any bus activity in progress is abandoned; the next START is required.

## Timing
- Detection latency from a bus pin to an internal edge or condition is 3 `clk` cycles.
- `sda` drive changes 1 `clk` after the detected `scl_fall`.
- The bus must hold `scl` high ≥ 4 `clk` and low ≥ 4 `clk`, with data setup ≥ 4 `clk` before `scl` rises.
- `wr_valid` pulses for exactly 1 cycle, 1 `clk` after the 8th `scl_rise` is detected.
- `host_data` is combinational. A bus write is visible on `host_data` the cycle after `wr_valid`.
- Simultaneous START/STOP detection and a `scl` edge in the same cycle: the START/STOP takes priority.
- The pointer wraps `NUM_REGS-1` → 0 with no error or flag.

## Structure
- Shared package `i2c_pkg`:
  - state encoding constants (shared with the master's 3-bit `state` style);
  - `I2C_RW_WRITE` = 0 and `I2C_RW_READ` = 1;
  - the default target address.
- One sub-module, `i2c_bus_sync`:
  - 2-flop synchronizers plus history register;
  - outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `sda_s`.
- The FSM, shift register and register bank stay in `i2c_reg_target`.

## Test plan
- Write, address 0x55 W: pointer 0x01, data 0x2B, 0x3C, STOP → ACK on all three bytes; `regs[1]`=0x2B, `regs[2]`=0x3C; two `wr_valid` pulses with `wr_addr` 1 then 2.
- Read after a repeated START: W with pointer 0x01, repeated START, R, master ACK then NACK → returns 0x2B then 0x3C; `sda` released after the NACK; `busy`=0.
- Address mismatch, 0x54 W with data 0x93 → `sda` never driven low; registers unchanged; `wr_valid` never asserted; state = IGNORE until STOP.
- Pointer wrap: pointer 0x03, data 0xA1, 0xB2 → `regs[3]`=0xA1, `regs[0]`=0xB2. Pointer byte 0x07 with NUM_REGS=4 → `ptr`=3.
- Reset mid-RX: assert `reset` after 4 data bits, release, then a full write of 0x93 to pointer 0 → all registers read 0 right after reset; the next transaction completes normally with `regs[0]`=0x93.
